// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request channel and a single-port word memory.
// Sub-word stores are read-modify-write; the memory read bus is byte-reversed.
module mem_access_unit #(
    parameter int MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqData,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respData,
    output logic        respErr,
    output logic        memREn,
    output logic        memWEn,
    output logic [31:0] memAddr,
    output logic [31:0] memDataOut,
    input  logic [31:0] memDataIn,
    output logic [1:0]  dbgState
);

    // Handshakes: a request transfers on a posedge where reqValid && reqReady;
    // a response transfers on a posedge where respValid && respReady. Once
    // raised, respValid/respData/respErr hold until that transfer.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

    state_t      state;
    state_t      state_n;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic        err_q;
    logic [31:0] raw_q;

    logic        accept;
    logic        size_err;
    logic        range_err;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    function automatic logic [31:0] byte_rev(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign accept   = (state == IDLE) && reqValid;
    assign dbgState = state;

    // Request checks are evaluated on the live inputs at the acceptance edge.
    always_comb begin
        size_err  = (reqSize == 2'b11)
                  || ((reqSize == SIZE_HALF) && reqAddr[0])
                  || ((reqSize == SIZE_WORD) && (reqAddr[1:0] != 2'b00));
        range_err = ({2'b00, reqAddr[31:2]} >= WORD_LIMIT);
        req_err   = size_err || range_err;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    if (req_err)
                        state_n = RESP;
                    else if (!reqWrite)
                        state_n = RD;
                    else if (reqSize == SIZE_WORD)
                        state_n = WR;
                    else
                        state_n = RD;
                end
            end
            RD:      state_n = lat_write ? WR : RESP;
            WR:      state_n = RESP;
            RESP:    state_n = respReady ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_write  <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_addr   <= 32'h0;
            lat_data   <= 32'h0;
            err_q      <= 1'b0;
            raw_q      <= 32'h0;
        end else begin
            state <= state_n;
            if (accept) begin
                lat_write  <= reqWrite;
                lat_size   <= reqSize;
                lat_signed <= reqSigned;
                lat_addr   <= reqAddr;
                lat_data   <= reqData;
                err_q      <= req_err;
            end
            if (state == RD)
                raw_q <= byte_rev(memDataIn);
        end
    end

    // Little-endian lane selection from the un-reversed word.
    always_comb begin
        byte_sel = 8'h00;
        case (lat_addr[1:0])
            2'd0:    byte_sel = raw_q[7:0];
            2'd1:    byte_sel = raw_q[15:8];
            2'd2:    byte_sel = raw_q[23:16];
            default: byte_sel = raw_q[31:24];
        endcase
        half_sel = lat_addr[1] ? raw_q[31:16] : raw_q[15:0];
    end

    always_comb begin
        load_val = raw_q;
        case (lat_size)
            SIZE_BYTE: load_val = lat_signed ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h0, byte_sel};
            SIZE_HALF: load_val = lat_signed ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0, half_sel};
            default:   load_val = raw_q;
        endcase
    end

    always_comb begin
        merged = raw_q;
        case (lat_size)
            SIZE_BYTE: begin
                case (lat_addr[1:0])
                    2'd0:    merged[7:0]   = lat_data[7:0];
                    2'd1:    merged[15:8]  = lat_data[7:0];
                    2'd2:    merged[23:16] = lat_data[7:0];
                    default: merged[31:24] = lat_data[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lat_addr[1])
                    merged[31:16] = lat_data[15:0];
                else
                    merged[15:0]  = lat_data[15:0];
            end
            default: merged = lat_data;
        endcase
    end

    // Write enable is gated by rst so an edge with reset asserted never stores.
    always_comb begin
        reqReady   = (state == IDLE);
        respValid  = (state == RESP);
        respErr    = (state == RESP) && err_q;
        respData   = ((state == RESP) && !err_q && !lat_write) ? load_val : 32'h0;
        memREn     = (state == RD);
        memWEn     = (state == WR) && !rst;
        memAddr    = ((state == RD) || (state == WR)) ? {2'b00, lat_addr[31:2]} : 32'h0;
        memDataOut = (state == WR) ? merged : 32'h0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-reversing word memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic        respErr;
    logic        memREn;
    logic        memWEn;
    logic [31:0] memAddr;
    logic [31:0] memDataOut;
    logic [31:0] memDataIn;
    logic [1:0]  dbgState;

    logic [31:0] mem [0:127];
    logic        pre_we;
    logic [6:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] raw_rd;

    logic [31:0] exp_q[$];
    int          n_vec;
    int          n_err;

    mem_access_unit #(.MEM_WORDS(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqWrite   (reqWrite),
        .reqSize    (reqSize),
        .reqSigned  (reqSigned),
        .reqAddr    (reqAddr),
        .reqData    (reqData),
        .respValid  (respValid),
        .respReady  (respReady),
        .respData   (respData),
        .respErr    (respErr),
        .memREn     (memREn),
        .memWEn     (memWEn),
        .memAddr    (memAddr),
        .memDataOut (memDataOut),
        .memDataIn  (memDataIn),
        .dbgState   (dbgState)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational byte-reversed read, posedge write.
    assign raw_rd    = mem[memAddr[6:0]];
    assign memDataIn = {raw_rd[7:0], raw_rd[15:8], raw_rd[23:16], raw_rd[31:24]};

    always @(posedge clk) begin
        if (memWEn)
            mem[memAddr[6:0]] <= memDataOut;
        else if (pre_we)
            mem[pre_addr] <= pre_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [6:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk); #1;
        pre_we   = 1'b0;
    endtask

    // Issues one request, then watches until respValid (bounded) without consuming it.
    task automatic run_req(input string tag, input logic w, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] d,
                           input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                           input int exp_ren, input int exp_wen,
                           input logic [31:0] exp_maddr, input logic [31:0] exp_wdata);
        int          lat;
        int          ren;
        int          wen;
        int          both;
        logic [31:0] seen_addr;
        logic [31:0] seen_wdata;
        lat = 0; ren = 0; wen = 0; both = 0;
        seen_addr = 32'h0; seen_wdata = 32'h0;
        reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg;
        reqAddr = a; reqData = d;
        check({tag, "_ready"}, {31'h0, reqReady}, 32'h1);
        @(posedge clk); #1;
        reqValid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (memREn && memWEn) both++;
            if (memREn) begin ren++; seen_addr = memAddr; end
            if (memWEn) begin wen++; seen_addr = memAddr; seen_wdata = memDataOut; end
            if (respValid) begin lat = k; break; end
            @(posedge clk); #1;
        end
        exp_q.push_back(exp_data);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, respData, exp_q.pop_front());
        check({tag, "_err"}, {31'h0, respErr}, {31'h0, exp_err});
        check({tag, "_ren"}, 32'(ren), 32'(exp_ren));
        check({tag, "_wen"}, 32'(wen), 32'(exp_wen));
        check({tag, "_both"}, 32'(both), 32'h0);
        if (exp_ren + exp_wen > 0)
            check({tag, "_maddr"}, seen_addr, exp_maddr);
        if (exp_wen > 0)
            check({tag, "_wdata"}, seen_wdata, exp_wdata);
    endtask

    task automatic consume(input string tag);
        respReady = 1'b1;
        @(posedge clk); #1;
        respReady = 1'b0;
        check({tag, "_rv_low"}, {31'h0, respValid}, 32'h0);
        check({tag, "_idle_ready"}, {31'h0, reqReady}, 32'h1);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
        reqSigned = 1'b0; reqAddr = 32'h0; reqData = 32'h0; respReady = 1'b0;
        pre_we = 1'b0; pre_addr = 7'h0; pre_data = 32'h0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        check("rst_ready", {31'h0, reqReady}, 32'h1);
        check("rst_rvalid", {31'h0, respValid}, 32'h0);
        check("rst_rerr", {31'h0, respErr}, 32'h0);
        check("rst_rdata", respData, 32'h0);
        check("rst_ren", {31'h0, memREn}, 32'h0);
        check("rst_wen", {31'h0, memWEn}, 32'h0);
        check("rst_maddr", memAddr, 32'h0);
        check("rst_mdout", memDataOut, 32'h0);
        check("rst_state", {30'h0, dbgState}, 32'h0);
        rst = 1'b0;

        // Word load
        preload(7'd5, 32'h11223344);
        run_req("ld_w", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 2, 32'h11223344, 1'b0, 1, 0, 32'd5, 32'h0);
        consume("ld_w");

        // Sub-word loads, signed and unsigned
        preload(7'd5, 32'h80FF7F01);
        run_req("ld_bs15", 1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 2, 32'h0000007F, 1'b0, 1, 0, 32'd5, 32'h0);
        consume("ld_bs15");
        run_req("ld_bs16", 1'b0, 2'b00, 1'b1, 32'h16, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 1, 0, 32'd5, 32'h0);
        consume("ld_bs16");
        run_req("ld_hu16", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 2, 32'h000080FF, 1'b0, 1, 0, 32'd5, 32'h0);
        consume("ld_hu16");
        run_req("ld_hs16", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 2, 32'hFFFF80FF, 1'b0, 1, 0, 32'd5, 32'h0);
        consume("ld_hs16");
        run_req("ld_bu17", 1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 2, 32'h00000080, 1'b0, 1, 0, 32'd5, 32'h0);
        consume("ld_bu17");

        // Sub-word stores (read-modify-write) and a word store
        preload(7'd5, 32'h11223344);
        run_req("st_h16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000BEEF, 3, 32'h0, 1'b0, 1, 1, 32'd5, 32'hBEEF3344);
        consume("st_h16");
        check("st_h16_mem", mem[5], 32'hBEEF3344);
        run_req("st_b15", 1'b1, 2'b00, 1'b0, 32'h15, 32'h123456AA, 3, 32'h0, 1'b0, 1, 1, 32'd5, 32'hBEEFAA44);
        consume("st_b15");
        check("st_b15_mem", mem[5], 32'hBEEFAA44);
        run_req("st_w18", 1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFEF00D, 2, 32'h0, 1'b0, 0, 1, 32'd6, 32'hCAFEF00D);
        consume("st_w18");
        check("st_w18_mem", mem[6], 32'hCAFEF00D);

        // Rejected requests
        run_req("er_w13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 32'h0);
        consume("er_w13");
        run_req("er_w200", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 32'h0);
        consume("er_w200");
        run_req("er_sz3", 1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 32'h0);
        consume("er_sz3");
        run_req("er_h15", 1'b1, 2'b01, 1'b0, 32'h15, 32'hFFFF, 1, 32'h0, 1'b1, 0, 0, 32'h0, 32'h0);
        consume("er_h15");
        check("er_h15_mem", mem[5], 32'hBEEFAA44);
        run_req("ok_w1fc", 1'b1, 2'b10, 1'b0, 32'h1FC, 32'h55AA55AA, 2, 32'h0, 1'b0, 0, 1, 32'd127, 32'h55AA55AA);
        consume("ok_w1fc");

        // Reset during the WR cycle of a word store
        preload(7'd7, 32'h01020304);
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqSigned = 1'b0;
        reqAddr = 32'h1C; reqData = 32'hDEADBEEF;
        @(posedge clk); #1;
        reqValid = 1'b0;
        check("rwr_wen_pre", {31'h0, memWEn}, 32'h1);
        rst = 1'b1;
        #1;
        check("rwr_wen_gated", {31'h0, memWEn}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rwr_ready", {31'h0, reqReady}, 32'h1);
        check("rwr_rvalid", {31'h0, respValid}, 32'h0);
        @(posedge clk); #1;
        check("rwr_rvalid2", {31'h0, respValid}, 32'h0);
        check("rwr_mem", mem[7], 32'h01020304);

        // Response back-pressure, then back-to-back acceptance
        run_req("bp_ld", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 2, 32'hBEEFAA44, 1'b0, 1, 0, 32'd5, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_rvalid", {31'h0, respValid}, 32'h1);
            check("bp_rdata", respData, 32'hBEEFAA44);
            check("bp_rerr", {31'h0, respErr}, 32'h0);
            check("bp_ready", {31'h0, reqReady}, 32'h0);
        end
        respReady = 1'b1;
        @(posedge clk); #1;
        respReady = 1'b0;
        run_req("bp_next", 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 2, 32'hCAFEF00D, 1'b0, 1, 0, 32'd6, 32'h0);
        consume("bp_next");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: MEM_WORDS, default 128, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: reqValid  input  1  CPU request valid.
REQ-005 SHALL have port: reqReady  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port: reqWrite  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: reqSize  input  2  00 byte, 01 halfword, 10 word; 11 illegal.
REQ-008 SHALL have port: reqSigned  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port: reqAddr  input  32  byte address.
REQ-010 SHALL have port: reqData  input  32  store data, right-aligned.
REQ-011 SHALL have port: respValid  output  1  response available.
REQ-012 SHALL have port: respReady  input  1  CPU consumes response.
REQ-013 SHALL have port: respData  output  32  load result; 0 for stores and errors.
REQ-014 SHALL have port: respErr  output  1  request rejected.
REQ-015 SHALL have port: memREn  output  1  data memory read enable.
REQ-016 SHALL have port: memWEn  output  1  data memory write enable; memory writes on posedge.
REQ-017 SHALL have port: memAddr  output  32  word address = reqAddr >> 2.
REQ-018 SHALL have port: memDataOut  output  32  raw word to memory.
REQ-019 SHALL have port: memDataIn  input  32  combinational memory read data, byte-reversed: {raw[7:0],raw[15:8],raw[23:16],raw[31:24]}.

Function
REQ-020 SHALL implement FSM states IDLE, RD, WR, RESP; reqReady = 1 only in IDLE.
REQ-021 SHALL, on reqValid & reqReady, latch reqWrite/reqSize/reqSigned/reqAddr/reqData.
REQ-022 SHALL detect errors at acceptance: reqSize=11, halfword with addr[0]=1, word with addr[1:0]!=0, or (reqAddr>>2) >= MEM_WORDS; an erroneous request goes IDLE->RESP, respErr=1, with no memREn/memWEn.
REQ-023 SHALL route valid requests: load -> RD; byte/halfword store -> RD (read-modify-write); word store -> WR.
REQ-024 SHALL, in RD, assert memREn for exactly one cycle and register the un-reversed word raw = byte-reverse(memDataIn); it then goes to RESP for loads and to WR for stores.
REQ-025 SHALL, in WR, assert memWEn for exactly one cycle with memDataOut = merged word, then go to RESP.
REQ-026 SHALL select byte lanes little-endian: byte k = raw[8k+7:8k], where k = addr[1:0]; halfword = lanes addr[1]*2 and addr[1]*2+1.
REQ-027 SHALL merge stores as follows: byte -> reqData[7:0] replaces lane k; halfword -> reqData[15:0] replaces the selected halfword; word -> reqData unchanged.
REQ-028 SHALL form load results as follows: extracted byte or halfword zero-extended, or sign-extended from its MSB when reqSigned=1; word loads return raw.
REQ-029 SHALL hold respValid, respData and respErr stable in RESP until respReady=1, then return to IDLE; the next request can be accepted in the following cycle.
REQ-030 SHALL never assert memREn and memWEn together; in all states other than RD/WR both are 0, memAddr is 0 and memDataOut is 0.
REQ-031 SHALL have these latencies (acceptance edge = T, cycles until respValid): word/sub-word load 2, word store 2, sub-word store 3, error 1.
REQ-032 SHALL gate memWEn combinationally with !rst, so that no memory write occurs on an edge where rst=1.

Reset
REQ-033 SHALL, on rst=1 at posedge, set state IDLE and clear all latched registers; next-cycle outputs: reqReady=1, respValid=0, respErr=0, respData=0, memREn=0, memWEn=0, memAddr=0, memDataOut=0.
REQ-034 SHALL abandon any in-flight operation on reset (including in RD/WR/RESP); no response is produced for it.

Verification
REQ-035 SHALL be tested with: mem[5]=0x11223344 (memDataIn 0x44332211), word load at 0x14 -> memREn 1 cycle, memAddr=5, respData=0x11223344 two cycles after acceptance.
REQ-036 SHALL be tested with: mem[5]=0x80FF7F01, signed byte loads at 0x15 and 0x16 -> 0x0000007F and 0xFFFFFFFF; unsigned halfword load at 0x16 -> 0x000080FF.
REQ-037 SHALL be tested with: mem[5]=0x11223344, halfword store 0xBEEF at 0x16 -> RD then WR, with memDataOut=0xBEEF3344 and respValid three cycles after acceptance.
REQ-038 SHALL be tested with: word load at 0x13, and word load at 0x200 (MEM_WORDS=128) -> respErr=1 and respData=0 the next cycle, with memREn and memWEn never asserted.
REQ-039 SHALL be tested with: rst asserted during the WR cycle of a store -> mem word unchanged, unit in IDLE with reqReady=1, and no respValid.
REQ-040 SHALL be tested with: respReady held 0 for 3 cycles in RESP -> response held stable and reqReady=0 throughout; acceptance of the next request one cycle after respReady=1.
